// File: rtl/go_pkg.sv
// Shared Go types: cell codes, 9x9 board layout and board_rx framing constants.
// Used by board_rx and the game state machine.
package go_pkg;

    typedef logic [1:0] cell_t;

    localparam cell_t CELL_E = 2'b00;
    localparam cell_t CELL_B = 2'b01;
    localparam cell_t CELL_W = 2'b10;
    localparam cell_t CELL_X = 2'b11;

    localparam int BOARD_N       = 9;
    localparam int NUM_CELLS     = BOARD_N * BOARD_N;
    localparam int PAYLOAD_BYTES = 21;

    typedef cell_t [BOARD_N-1:0][BOARD_N-1:0] board_t;
    // Flat cell list; cell k sits at the same bit offset as board[k/9][k%9].
    typedef cell_t [NUM_CELLS-1:0] cells_t;

    localparam logic [7:0] BOARD_RX_HEADER      = 8'hA5;
    localparam int         BOARD_RX_TIMEOUT_CYC = 100000;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_PAYLOAD,
        RX_CHECK,
        RX_COMMIT,
        RX_ERROR
    } rx_state_t;

endpackage

// File: rtl/board_rx_if.sv
// Byte stream in, committed board and frame status out.
// master = UART/game side driving bytes, slave = board_rx.
interface board_rx_if;
    import go_pkg::*;

    logic [7:0] rx_data;
    logic       rx_valid;
    board_t     board_out;
    logic       rx_ready;
    logic       frame_ok;
    logic       frame_err;

    modport master (
        output rx_data, rx_valid,
        input  board_out, rx_ready, frame_ok, frame_err
    );

    modport slave (
        input  rx_data, rx_valid,
        output board_out, rx_ready, frame_ok, frame_err
    );

endinterface

// File: rtl/board_rx_timer.sv
// Saturating inter-byte gap counter; o_expired is high while the count equals LIMIT.
// Clear wins over enable; the count never wraps.
module board_rx_timer #(
    parameter int LIMIT = 100000
) (
    input  logic clk_in,
    input  logic reset_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired
);

    localparam int CW = $clog2(LIMIT + 1);
    localparam logic [CW-1:0] LIMIT_W = CW'(LIMIT);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk_in) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en && r_cnt != LIMIT_W) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    assign o_expired = (r_cnt == LIMIT_W);

endmodule

// File: rtl/board_rx.sv
// Frame receiver: header + 21 payload bytes (+ XOR checksum when BOARD_RX_CHECKSUM_EN) -> 9x9 board.
// Outputs update one cycle after the last byte; no backpressure, bytes in COMMIT/ERROR are dropped.
module board_rx
    import go_pkg::*;
#(
    parameter int TIMEOUT_CYC = BOARD_RX_TIMEOUT_CYC
) (
    input  logic        clk_in,
    input  logic        reset_n,
    board_rx_if.slave   rx
);

    rx_state_t  r_state;
    logic [4:0] r_cnt;
    cells_t     r_shadow;
    logic       r_illegal;
    board_t     r_board;
    logic       r_ready;
    logic       r_ok;
    logic       r_err;
`ifdef BOARD_RX_CHECKSUM_EN
    logic [7:0] r_acc;
`endif

    logic [6:0] w_base;
    logic       w_byte_illegal;
    logic       w_illegal_nxt;
    logic       w_last;
    logic       w_timer_en;
    logic       w_timeout;

    assign w_base        = {r_cnt, 2'b00};
    assign w_last        = (r_cnt == 5'(PAYLOAD_BYTES - 1));
    assign w_illegal_nxt = r_illegal | w_byte_illegal;
    assign w_timer_en    = (r_state == RX_PAYLOAD) || (r_state == RX_CHECK);

    // Only cells that exist count; the unused top bits of the last byte are ignored.
    always_comb begin
        w_byte_illegal = 1'b0;
        for (int j = 0; j < 4; j++) begin
            if ((w_base + 7'(j)) < 7'(NUM_CELLS) && rx.rx_data[2*j +: 2] == CELL_X) begin
                w_byte_illegal = 1'b1;
            end
        end
    end

    board_rx_timer #(
        .LIMIT (TIMEOUT_CYC)
    ) u_timer (
        .clk_in    (clk_in),
        .reset_n   (reset_n),
        .i_clr     (rx.rx_valid || !w_timer_en),
        .i_en      (w_timer_en),
        .o_expired (w_timeout)
    );

    always_ff @(posedge clk_in) begin
        if (!reset_n) begin
            r_state   <= RX_IDLE;
            r_cnt     <= '0;
            r_shadow  <= '0;
            r_illegal <= 1'b0;
            r_board   <= '0;
            r_ready   <= 1'b0;
            r_ok      <= 1'b0;
            r_err     <= 1'b0;
`ifdef BOARD_RX_CHECKSUM_EN
            r_acc     <= '0;
`endif
        end else begin
            r_ok  <= 1'b0;
            r_err <= 1'b0;
            case (r_state)
                RX_IDLE: begin
                    if (rx.rx_valid && rx.rx_data == BOARD_RX_HEADER) begin
                        r_state   <= RX_PAYLOAD;
                        r_cnt     <= '0;
                        r_illegal <= 1'b0;
`ifdef BOARD_RX_CHECKSUM_EN
                        r_acc     <= '0;
`endif
                    end
                end
                RX_PAYLOAD: begin
                    if (w_timeout) begin
                        r_state <= RX_ERROR;
                    end else if (rx.rx_valid) begin
                        for (int j = 0; j < 4; j++) begin
                            if ((w_base + 7'(j)) < 7'(NUM_CELLS)) begin
                                r_shadow[w_base + 7'(j)] <= rx.rx_data[2*j +: 2];
                            end
                        end
                        r_illegal <= w_illegal_nxt;
                        r_cnt     <= r_cnt + 5'd1;
`ifdef BOARD_RX_CHECKSUM_EN
                        r_acc     <= r_acc ^ rx.rx_data;
                        if (w_last) begin
                            r_state <= RX_CHECK;
                        end
`else
                        if (w_last) begin
                            r_state <= w_illegal_nxt ? RX_ERROR : RX_COMMIT;
                        end
`endif
                    end
                end
`ifdef BOARD_RX_CHECKSUM_EN
                RX_CHECK: begin
                    if (w_timeout) begin
                        r_state <= RX_ERROR;
                    end else if (rx.rx_valid) begin
                        r_state <= (rx.rx_data == r_acc && !r_illegal) ? RX_COMMIT : RX_ERROR;
                    end
                end
`endif
                RX_COMMIT: begin
                    r_board <= board_t'(r_shadow);
                    r_ready <= 1'b1;
                    r_ok    <= 1'b1;
                    r_state <= RX_IDLE;
                end
                RX_ERROR: begin
                    r_err   <= 1'b1;
                    r_state <= RX_IDLE;
                end
                default: begin
                    r_state <= RX_IDLE;
                end
            endcase
        end
    end

    assign rx.board_out = r_board;
    assign rx.rx_ready  = r_ready;
    assign rx.frame_ok  = r_ok;
    assign rx.frame_err = r_err;

endmodule

// File: tb/tb_board_rx.sv
// Directed bench for board_rx with a frame-level reference model and a per-cycle compare.
module tb_board_rx;
    import go_pkg::*;

    localparam int T = 40;
`ifdef BOARD_RX_CHECKSUM_EN
    localparam int FRAME_LEN = 23;
`else
    localparam int FRAME_LEN = 22;
`endif

    typedef logic [7:0] frm_t [22];

    logic clk_in = 1'b0;
    logic reset_n;
    board_rx_if bus ();

    board_rx #(.TIMEOUT_CYC(T)) dut (
        .clk_in  (clk_in),
        .reset_n (reset_n),
        .rx      (bus)
    );

    always #5 clk_in = ~clk_in;

    int n_checks = 0;
    int n_fail   = 0;
    int ok_cnt   = 0;
    int err_cnt  = 0;
    bit cmp_en   = 1'b0;

    task automatic chk(input string nm, input logic [161:0] act, input logic [161:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: collects frame bytes, decides at the last byte, shows the result one edge later.
    logic [7:0] mq[$];
    bit     m_in = 0;
    int     m_gap = 0;
    int     m_pend = 0;
    board_t m_pend_board = '0;
    board_t m_board = '0;
    bit     m_ready = 0, m_ok = 0, m_err = 0;

    function automatic void judge();
        bit     bad = 0;
        board_t b = '0;
        logic [1:0] c;
        logic [7:0] x = 8'h00;
        for (int k = 0; k < 81; k++) begin
            c = 2'((mq[k/4] >> (2*(k%4))) & 8'h03);
            if (c == 2'b11) bad = 1;
            b[k/9][k%9] = c;
        end
`ifdef BOARD_RX_CHECKSUM_EN
        for (int i = 0; i < 21; i++) x ^= mq[i];
        if (x != mq[21]) bad = 1;
`endif
        m_pend_board = b;
        m_pend = bad ? 2 : 1;
    endfunction

    always @(posedge clk_in) begin
        if (!reset_n) begin
            m_in = 0; mq.delete(); m_gap = 0; m_pend = 0;
            m_board = '0; m_ready = 0; m_ok = 0; m_err = 0;
        end else begin
            m_ok = 0; m_err = 0;
            if (m_pend == 1) begin
                m_board = m_pend_board; m_ready = 1; m_ok = 1; m_pend = 0;
            end else if (m_pend == 2) begin
                m_err = 1; m_pend = 0;
            end else if (m_in) begin
                if (m_gap >= T) begin
                    m_in = 0; m_pend = 2;
                end else if (bus.rx_valid) begin
                    mq.push_back(bus.rx_data);
                    m_gap = 0;
                    if (mq.size() == FRAME_LEN - 1) begin
                        m_in = 0;
                        judge();
                    end
                end else begin
                    m_gap++;
                end
            end else if (bus.rx_valid && bus.rx_data == 8'hA5) begin
                m_in = 1; mq.delete(); m_gap = 0;
            end
        end
    end

    always @(negedge clk_in) begin
        if (cmp_en) begin
            chk("cmp_board", bus.board_out, m_board);
            chk("cmp_ready", bus.rx_ready, m_ready);
            chk("cmp_ok", bus.frame_ok, m_ok);
            chk("cmp_err", bus.frame_err, m_err);
        end
        if (bus.frame_ok === 1'b1) ok_cnt++;
        if (bus.frame_err === 1'b1) err_cnt++;
    end

    task automatic send(input logic [7:0] b);
        @(negedge clk_in);
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk_in);
            bus.rx_valid = 1'b0;
            bus.rx_data  = 8'h00;
        end
    endtask

    task automatic send_frame(input frm_t f);
        send(8'hA5);
        for (int i = 0; i < FRAME_LEN - 1; i++) send(f[i]);
    endtask

    frm_t f_good, f_bad_ck, f_ill, f_hdr;
    int   ok0, err0;

    initial begin
        // Cells 1,9,10 black; 70,71,79,80 white. XOR of payload = 8'h32.
        for (int i = 0; i < 22; i++) f_good[i] = 8'h00;
        f_good[0] = 8'h04; f_good[2] = 8'h14; f_good[17] = 8'hA0;
        f_good[19] = 8'h80; f_good[20] = 8'h02; f_good[21] = 8'h32;
        f_bad_ck = f_good; f_bad_ck[21] = 8'h33;
        f_ill = f_good; f_ill[0] = 8'h03; f_ill[21] = 8'h35;
        f_hdr = f_good; f_hdr[3] = 8'hA5; f_hdr[21] = 8'h97;

        reset_n = 1'b0; bus.rx_valid = 1'b0; bus.rx_data = 8'h00;
        repeat (3) @(negedge clk_in);
        cmp_en = 1'b1;
        chk("rst_board", bus.board_out, '0);
        chk("rst_ready", bus.rx_ready, 0);
        chk("rst_ok", bus.frame_ok, 0);
        chk("rst_err", bus.frame_err, 0);
        reset_n = 1'b1;
        idle(2);

        // Valid frame, timing pinned to edge N+1
        ok0 = ok_cnt;
        send_frame(f_good);
        idle(1);
        chk("t1_ok_at_N", bus.frame_ok, 0);
        chk("t1_ready_at_N", bus.rx_ready, 0);
        idle(1);
        chk("t1_ok_at_N1", bus.frame_ok, 1);
        chk("t1_ready_at_N1", bus.rx_ready, 1);
        chk("t1_c0", bus.board_out[0][0], 2'b00);
        chk("t1_c1", bus.board_out[0][1], 2'b01);
        chk("t1_c9", bus.board_out[1][0], 2'b01);
        chk("t1_c10", bus.board_out[1][1], 2'b01);
        chk("t1_c70", bus.board_out[7][7], 2'b10);
        chk("t1_c71", bus.board_out[7][8], 2'b10);
        chk("t1_c79", bus.board_out[8][7], 2'b10);
        chk("t1_c80", bus.board_out[8][8], 2'b10);
        chk("t1_model_c80", m_board[8][8], 2'b10);
        chk("t1_model_c10", m_board[1][1], 2'b01);
        idle(1);
        chk("t1_ok_drop", bus.frame_ok, 0);
        idle(2);
        chk("t1_ok_count", ok_cnt - ok0, 1);

        // Corrupted checksum from reset
        reset_n = 1'b0; idle(2); reset_n = 1'b1; idle(2);
        ok0 = ok_cnt; err0 = err_cnt;
        send_frame(f_bad_ck);
        idle(4);
`ifdef BOARD_RX_CHECKSUM_EN
        chk("t2_err_count", err_cnt - err0, 1);
        chk("t2_board", bus.board_out, '0);
        chk("t2_ready", bus.rx_ready, 0);
`else
        chk("t2_ok_count", ok_cnt - ok0, 1);
`endif

        // Junk before header; a header during COMMIT is dropped
        ok0 = ok_cnt;
        send(8'h00); send(8'h13);
        send_frame(f_good);
        send(8'hA5);
        idle(4);
        chk("t3_ok_count", ok_cnt - ok0, 1);
        chk("t3_c71", bus.board_out[7][8], 2'b10);

        // Stall after payload byte 5
        ok0 = ok_cnt; err0 = err_cnt;
        send(8'hA5);
        for (int i = 0; i < 6; i++) send(f_good[i]);
        idle(T + 6);
        chk("t4_err_count", err_cnt - err0, 1);
        send_frame(f_good);
        idle(4);
        chk("t4_ok_count", ok_cnt - ok0, 1);

        // Header value as payload data
        ok0 = ok_cnt;
        send_frame(f_hdr);
        idle(4);
        chk("t5_ok_count", ok_cnt - ok0, 1);
        chk("t5_c12", bus.board_out[1][3], 2'b01);
        chk("t5_c15", bus.board_out[1][6], 2'b10);

        // Illegal cell 0 keeps previous board
        err0 = err_cnt;
        send_frame(f_ill);
        idle(4);
        chk("t6_err_count", err_cnt - err0, 1);
        chk("t6_c1_kept", bus.board_out[1][3], 2'b01);
        chk("t6_ready", bus.rx_ready, 1);

        // Reset mid-payload
        err0 = err_cnt;
        send(8'hA5); send(f_good[0]); send(f_good[1]); send(f_good[2]);
        @(negedge clk_in);
        reset_n = 1'b0; bus.rx_valid = 1'b0;
        idle(2);
        reset_n = 1'b1;
        idle(T + 4);
        chk("t7_err_count", err_cnt - err0, 0);
        chk("t7_board", bus.board_out, '0);
        chk("t7_ready", bus.rx_ready, 0);
        chk("t7_ok", bus.frame_ok, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
